// File: rtl/fp_seq_mlp.sv
// fp_seq_mlp: streaming two-layer fixed-point perceptron.
// Samples arrive MAIN_TAP at a time into a TOTAL_TAP-deep window. Every accepted word
// that leaves the window full starts one inference, evaluated by a single shared MAC:
// first the hidden layer (optional ReLU), then the output layer.
//
// Window index t = 0 holds the oldest sample. The newest word occupies
// t = TOTAL_TAP-MAIN_TAP .. TOTAL_TAP-1, with its sample 0 at the lower index.
// Weight layout:
//   weight_input_to_hidden : element (h*TOTAL_TAP + t) multiplies window[t] into hidden h
//   weight_hidden_to_output: element (j*N_HIDDEN + h) multiplies hidden h into output j
module fp_seq_mlp #(
    parameter int DATA_WIDTH = 8,
    parameter int MAIN_TAP   = 2,
    parameter int PRE_TAP    = 1,
    parameter int POST_TAP   = 1,
    parameter int N_HIDDEN   = 4,
    parameter int FRAC       = 6,
    parameter int FLAG_LSB   = DATA_WIDTH - 3,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 8,
    localparam int TOTAL_TAP = PRE_TAP + MAIN_TAP + POST_TAP
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [DATA_WIDTH*MAIN_TAP-1:0]           in_data,
    input  logic [DATA_WIDTH*TOTAL_TAP*N_HIDDEN-1:0] weight_input_to_hidden,
    input  logic [DATA_WIDTH*N_HIDDEN*MAIN_TAP-1:0]  weight_hidden_to_output,
    input  logic [DATA_WIDTH*N_HIDDEN-1:0]           bias_hidden,
    input  logic [DATA_WIDTH*MAIN_TAP-1:0]           bias_output,
    input  logic                                     relu_en,
    input  logic                                     clear,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [DATA_WIDTH*MAIN_TAP-1:0]           decision_layer_output,
    output logic [2*MAIN_TAP-1:0]                    output_result
);

    // TOTAL_TAP >= MAIN_TAP always, so the longest counted span is TOTAL_TAP or N_HIDDEN
    localparam int MAX_LEN = (TOTAL_TAP > N_HIDDEN) ? TOTAL_TAP : N_HIDDEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int FILL_W  = $clog2(TOTAL_TAP + 1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));
    localparam logic signed [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StHid, StOut, StDone} state_e;

    state_e state_q, state_d;

    logic signed [DATA_WIDTH-1:0] window_q [TOTAL_TAP];
    logic signed [DATA_WIDTH-1:0] hid_q    [N_HIDDEN];
    logic signed [DATA_WIDTH-1:0] stage_q  [MAIN_TAP];
    logic [FILL_W-1:0]            fill_q;
    logic [CNT_W-1:0]             tap_q;
    logic [CNT_W-1:0]             neu_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;

    logic                         accept;
    logic                         trigger;
    logic                         full_next;
    logic [FILL_W:0]              fill_sum;
    logic [FILL_W-1:0]            fill_next;
    logic                         tap_last;
    logic                         neu_last;
    logic                         mac_en;

    logic signed [DATA_WIDTH-1:0]   mac_x;
    logic signed [DATA_WIDTH-1:0]   mac_w;
    logic signed [DATA_WIDTH-1:0]   mac_b;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    bias_ext;
    logic signed [ACC_WIDTH-1:0]    acc_base;
    logic signed [ACC_WIDTH-1:0]    acc_sum;
    logic signed [ACC_WIDTH-1:0]    acc_shr;
    logic signed [ACC_WIDTH-1:0]    act;
    logic signed [DATA_WIDTH-1:0]   res;

    logic [DATA_WIDTH*MAIN_TAP-1:0] dec_next;
    logic [2*MAIN_TAP-1:0]          flag_next;

    // Handshake and window fill bookkeeping; clear blocks any accept in the same cycle
    always_comb begin
        accept    = in_valid && in_ready && !clear;
        fill_sum  = {1'b0, fill_q} + (FILL_W + 1)'(MAIN_TAP);
        full_next = fill_sum >= (FILL_W + 1)'(TOTAL_TAP);
        fill_next = full_next ? FILL_W'(TOTAL_TAP) : fill_sum[FILL_W-1:0];
        trigger   = accept && full_next;
    end

    // End-of-neuron and end-of-layer detection for whichever layer is running
    always_comb begin
        if (state_q == StHid) begin
            tap_last = tap_q == CNT_W'(TOTAL_TAP - 1);
            neu_last = neu_q == CNT_W'(N_HIDDEN - 1);
        end else begin
            tap_last = tap_q == CNT_W'(N_HIDDEN - 1);
            neu_last = neu_q == CNT_W'(MAIN_TAP - 1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (trigger) state_d = StHid;
                StHid:   if (tap_last && neu_last) state_d = StOut;
                StOut:   if (tap_last && neu_last) state_d = StDone;
                StDone:  if (out_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        in_ready  = state_q == StIdle;
        out_valid = state_q == StDone;
        mac_en    = (state_q == StHid || state_q == StOut) && !clear;
    end

    // Sample window and fill counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q <= '0;
            for (int i = 0; i < TOTAL_TAP; i++) window_q[i] <= '0;
        end else if (clear) begin
            fill_q <= '0;
            for (int i = 0; i < TOTAL_TAP; i++) window_q[i] <= '0;
        end else if (accept) begin
            fill_q <= fill_next;
            for (int i = 0; i < TOTAL_TAP - MAIN_TAP; i++) window_q[i] <= window_q[i+MAIN_TAP];
            for (int k = 0; k < MAIN_TAP; k++) begin
                window_q[TOTAL_TAP-MAIN_TAP+k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // MAC operand selection for the current layer, neuron and tap
    always_comb begin
        mac_x = '0;
        mac_w = '0;
        mac_b = '0;
        if (state_q == StHid) begin
            for (int t = 0; t < TOTAL_TAP; t++) begin
                if (int'(tap_q) == t) mac_x = window_q[t];
            end
            for (int n = 0; n < N_HIDDEN; n++) begin
                if (int'(neu_q) == n) mac_b = bias_hidden[n*DATA_WIDTH +: DATA_WIDTH];
                for (int t = 0; t < TOTAL_TAP; t++) begin
                    if (int'(neu_q) == n && int'(tap_q) == t) begin
                        mac_w = weight_input_to_hidden[(n*TOTAL_TAP+t)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end else if (state_q == StOut) begin
            for (int h = 0; h < N_HIDDEN; h++) begin
                if (int'(tap_q) == h) mac_x = hid_q[h];
            end
            for (int j = 0; j < MAIN_TAP; j++) begin
                if (int'(neu_q) == j) mac_b = bias_output[j*DATA_WIDTH +: DATA_WIDTH];
                for (int h = 0; h < N_HIDDEN; h++) begin
                    if (int'(neu_q) == j && int'(tap_q) == h) begin
                        mac_w = weight_hidden_to_output[(j*N_HIDDEN+h)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Multiply-accumulate; first tap of a neuron starts from the bias aligned to the
    // product's binary point, and the finished neuron is rescaled, rectified and clamped
    always_comb begin
        prod     = mac_x * mac_w;
        bias_ext = ACC_WIDTH'(mac_b) <<< FRAC;
        acc_base = (tap_q == '0) ? bias_ext : acc_q;
        acc_sum  = acc_base + ACC_WIDTH'(prod);
        acc_shr  = acc_sum >>> FRAC;
        if (relu_en && state_q == StHid && acc_shr[ACC_WIDTH-1]) begin
            act = '0;
        end else begin
            act = acc_shr;
        end
        if (act > SAT_MAX) begin
            res = RES_MAX;
        end else if (act < SAT_MIN) begin
            res = RES_MIN;
        end else begin
            res = act[DATA_WIDTH-1:0];
        end
    end

    // Output word assembled from earlier staged neurons plus the one finishing now
    always_comb begin
        logic signed [DATA_WIDTH-1:0] val;
        dec_next  = '0;
        flag_next = '0;
        val       = '0;
        for (int j = 0; j < MAIN_TAP; j++) begin
            val = (int'(neu_q) == j) ? res : stage_q[j];
            dec_next[j*DATA_WIDTH +: DATA_WIDTH] = val;
            flag_next[2*j +: 2]                  = val[FLAG_LSB +: 2];
        end
    end

    // Accumulator, tap/neuron counters and per-layer result storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            tap_q <= '0;
            neu_q <= '0;
            for (int h = 0; h < N_HIDDEN; h++) hid_q[h] <= '0;
            for (int j = 0; j < MAIN_TAP; j++) stage_q[j] <= '0;
        end else if (clear || trigger) begin
            tap_q <= '0;
            neu_q <= '0;
        end else if (mac_en) begin
            acc_q <= acc_sum;
            if (tap_last) begin
                tap_q <= '0;
                neu_q <= neu_last ? '0 : neu_q + CNT_W'(1);
                if (state_q == StHid) begin
                    for (int h = 0; h < N_HIDDEN; h++) begin
                        if (int'(neu_q) == h) hid_q[h] <= res;
                    end
                end else begin
                    for (int j = 0; j < MAIN_TAP; j++) begin
                        if (int'(neu_q) == j) stage_q[j] <= res;
                    end
                end
            end else begin
                tap_q <= tap_q + CNT_W'(1);
            end
        end
    end

    // Visible results change only when a full inference completes, so an aborted
    // run never exposes a partial output word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            decision_layer_output <= '0;
            output_result         <= '0;
        end else if (mac_en && state_q == StOut && tap_last && neu_last) begin
            decision_layer_output <= dec_next;
            output_result         <= flag_next;
        end
    end

endmodule

// File: tb/tb_fp_seq_mlp.sv
// tb_fp_seq_mlp: scoreboard bench for fp_seq_mlp with an arithmetic reference model.
module tb_fp_seq_mlp;

    localparam int DW       = 8;
    localparam int MT       = 2;
    localparam int PT       = 1;
    localparam int QT       = 1;
    localparam int NH       = 4;
    localparam int FRAC     = 6;
    localparam int FLAG_LSB = DW - 3;
    localparam int TT       = PT + MT + QT;
    localparam int LAT      = 1 + NH * (TT + MT);

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW*MT-1:0]      in_data;
    logic [DW*TT*NH-1:0]   weight_input_to_hidden;
    logic [DW*NH*MT-1:0]   weight_hidden_to_output;
    logic [DW*NH-1:0]      bias_hidden;
    logic [DW*MT-1:0]      bias_output;
    logic                  relu_en;
    logic                  clear;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW*MT-1:0]      decision_layer_output;
    logic [2*MT-1:0]       output_result;

    typedef struct packed {
        logic [DW*MT-1:0] dec;
        logic [2*MT-1:0]  fl;
    } exp_t;

    int   wih [NH][TT];
    int   who [MT][NH];
    int   bh  [NH];
    int   bo  [MT];
    bit   relu;
    int   win [$];
    int   fill;
    exp_t exp_q [$];
    logic [DW*MT-1:0] last_dec;
    logic [2*MT-1:0]  last_fl;
    int   total = 0;
    int   bad   = 0;

    fp_seq_mlp #(
        .DATA_WIDTH (DW),
        .MAIN_TAP   (MT),
        .PRE_TAP    (PT),
        .POST_TAP   (QT),
        .N_HIDDEN   (NH),
        .FRAC       (FRAC),
        .FLAG_LSB   (FLAG_LSB),
        .ACC_WIDTH  (2 * DW + 8)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_data                 (in_data),
        .weight_input_to_hidden  (weight_input_to_hidden),
        .weight_hidden_to_output (weight_hidden_to_output),
        .bias_hidden             (bias_hidden),
        .bias_output             (bias_output),
        .relu_en                 (relu_en),
        .clear                   (clear),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .decision_layer_output   (decision_layer_output),
        .output_result           (output_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic int sat(input int v);
        int hi;
        int lo;
        hi = (2 ** (DW - 1)) - 1;
        lo = -(2 ** (DW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Drive the packed buses from the model's integer parameter arrays
    task automatic apply_params();
        logic [31:0] tmp;
        for (int h = 0; h < NH; h++) begin
            for (int t = 0; t < TT; t++) begin
                tmp = wih[h][t];
                weight_input_to_hidden[(h*TT+t)*DW +: DW] = tmp[DW-1:0];
            end
            tmp = bh[h];
            bias_hidden[h*DW +: DW] = tmp[DW-1:0];
        end
        for (int j = 0; j < MT; j++) begin
            for (int h = 0; h < NH; h++) begin
                tmp = who[j][h];
                weight_hidden_to_output[(j*NH+h)*DW +: DW] = tmp[DW-1:0];
            end
            tmp = bo[j];
            bias_output[j*DW +: DW] = tmp[DW-1:0];
        end
        relu_en = relu;
    endtask

    task automatic set_all(input int wi, input int wo, input int bhv, input int bov);
        for (int h = 0; h < NH; h++) begin
            bh[h] = bhv;
            for (int t = 0; t < TT; t++) wih[h][t] = wi;
        end
        for (int j = 0; j < MT; j++) begin
            bo[j] = bov;
            for (int h = 0; h < NH; h++) who[j][h] = wo;
        end
        apply_params();
    endtask

    task automatic randomize_params();
        for (int h = 0; h < NH; h++) begin
            bh[h] = int'($urandom_range(0, 255)) - 128;
            for (int t = 0; t < TT; t++) wih[h][t] = int'($urandom_range(0, 255)) - 128;
        end
        for (int j = 0; j < MT; j++) begin
            bo[j] = int'($urandom_range(0, 255)) - 128;
            for (int h = 0; h < NH; h++) who[j][h] = int'($urandom_range(0, 255)) - 128;
        end
        relu = 1'($urandom_range(0, 1));
        apply_params();
    endtask

    task automatic model_reset();
        win.delete();
        for (int t = 0; t < TT; t++) win.push_back(0);
        fill = 0;
    endtask

    // Reference network evaluated with plain integer arithmetic
    task automatic model_expect(output exp_t e);
        int          hid [NH];
        int          acc;
        int          r;
        logic [31:0] rb;
        for (int h = 0; h < NH; h++) begin
            acc = bh[h] * (2 ** FRAC);
            for (int t = 0; t < TT; t++) acc += wih[h][t] * win[t];
            r = acc >>> FRAC;
            if (relu && r < 0) r = 0;
            hid[h] = sat(r);
        end
        e = '0;
        for (int j = 0; j < MT; j++) begin
            acc = bo[j] * (2 ** FRAC);
            for (int h = 0; h < NH; h++) acc += who[j][h] * hid[h];
            rb = sat(acc >>> FRAC);
            e.dec[j*DW +: DW] = rb[DW-1:0];
            e.fl[2*j +: 2]    = rb[FLAG_LSB +: 2];
        end
    endtask

    // Offer one word; returns whether the model expects it to start an inference
    task automatic send_word(input int s0, input int s1, output bit trig);
        int          g;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
        g = 0;
        while (!in_ready && g < 400) begin
            @(negedge clk);
            g++;
        end
        check("in_ready_wait", 32'(g < 400), 1);
        a = s0;
        b = s1;
        in_data  = {b[DW-1:0], a[DW-1:0]};
        in_valid = 1'b1;
        win.push_back(s0);
        win.push_back(s1);
        void'(win.pop_front());
        void'(win.pop_front());
        fill = (fill + MT > TT) ? TT : fill + MT;
        trig = fill >= TT;
        if (trig) begin
            model_expect(e);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic measure_latency();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n + 1, LAT);
    endtask

    task automatic wait_result(input bit rnd);
        int n;
        n = 0;
        while (!in_ready && n < 400) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        check("result_timeout", 32'(n < 400), 1);
        out_ready = 1'b1;
    endtask

    // Monitor: every delivered output word is matched against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_dec", decision_layer_output, e.dec);
                    check("sb_flags", output_result, e.fl);
                    last_dec = e.dec;
                    last_fl  = e.fl;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit trig;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        clear     = 1'b0;
        relu      = 1'b0;
        reset_n   = 1'b1;
        last_dec  = '0;
        last_fl   = '0;
        weight_input_to_hidden  = '0;
        weight_hidden_to_output = '0;
        bias_hidden             = '0;
        bias_output             = '0;
        relu_en                 = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_dec", decision_layer_output, 0);
        check("rst_flags", output_result, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Warm-up and bias-only
        set_all(0, 0, 0, 'h60);
        send_word(5, -7, trig);
        check("warm1_in_ready", in_ready, 1);
        check("warm1_out_valid", out_valid, 0);
        send_word(3, 4, trig);
        check("warm2_in_ready", in_ready, 0);
        measure_latency();
        check("bias_dec", decision_layer_output, 16'h6060);
        check("bias_flags", output_result, 4'b1111);
        wait_result(0);

        // Saturation
        set_all(127, 127, 0, 0);
        send_word(127, 127, trig);
        wait_result(0);
        send_word(127, 127, trig);
        measure_latency();
        check("sat_dec", decision_layer_output, 16'h7f7f);
        check("sat_flags", output_result, 4'b1111);
        wait_result(0);

        // ReLU enabled, then disabled
        relu = 1'b1;
        set_all(-64, 64, 0, 'h20);
        send_word(64, 64, trig);
        wait_result(0);
        send_word(64, 64, trig);
        measure_latency();
        check("relu_dec", decision_layer_output, 16'h2020);
        check("relu_flags", output_result, 4'b0101);
        wait_result(0);
        relu = 1'b0;
        set_all(-64, 64, 0, 'h20);
        send_word(64, 64, trig);
        measure_latency();
        check("norelu_dec", decision_layer_output, 16'h8080);
        check("norelu_flags", output_result, 4'b0000);
        wait_result(0);

        // Back-pressure
        randomize_params();
        out_ready = 1'b0;
        send_word(10, -20, trig);
        measure_latency();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_dec", decision_layer_output, exp_q[0].dec);
            check("bp_flags", output_result, exp_q[0].fl);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);

        // Reset in the middle of the hidden layer
        send_word(33, -44, trig);
        repeat (5) @(posedge clk);
        #1 reset_n = 1'b0;
        #2;
        check("midrst_valid", out_valid, 0);
        check("midrst_dec", decision_layer_output, 0);
        check("midrst_flags", output_result, 0);
        check("midrst_ready", in_ready, 1);
        exp_q.delete();
        model_reset();
        last_dec = '0;
        last_fl  = '0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(-1, 2, trig);
        check("rewarm1_ready", in_ready, 1);
        check("rewarm1_valid", out_valid, 0);
        send_word(50, -60, trig);
        check("rewarm1b_ready", in_ready, 0);
        measure_latency();
        wait_result(0);

        // Clear in the middle of the output layer
        send_word(7, 8, trig);
        repeat (19) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("clr_valid", out_valid, 0);
        check("clr_ready", in_ready, 1);
        check("clr_dec_kept", decision_layer_output, last_dec);
        check("clr_flags_kept", output_result, last_fl);
        exp_q.delete();
        model_reset();
        repeat (30) @(posedge clk);
        #1;
        check("clr_quiet", out_valid, 0);
        send_word(90, -90, trig);
        check("rewarm2_ready", in_ready, 1);
        send_word(-5, 15, trig);
        check("rewarm2b_ready", in_ready, 0);
        measure_latency();
        wait_result(0);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 20; i++) begin
            randomize_params();
            send_word(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                      trig);
            wait_result(1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_seq_mlp.md
FP_SEQ_MLP -- requirements
Module: fp_seq_mlp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: signed sample, weight, bias and result width.
REQ-002 SHALL have parameter MAIN_TAP, default 2: new samples per input word and output neurons.
REQ-003 SHALL have parameters PRE_TAP and POST_TAP, default 1 each; localparam TOTAL_TAP = PRE_TAP+MAIN_TAP+POST_TAP.
REQ-004 SHALL have parameter N_HIDDEN, default 4: hidden neurons.
REQ-005 SHALL have parameter FRAC, default 6: fractional bits of weights; parameter FLAG_LSB, default DATA_WIDTH-3: decision flag bit position.
REQ-006 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+8: signed accumulator width.
REQ-007 SHALL have ports: clk, in, 1, sole clock, rising edge; reset_n, in, 1, asynchronous, active-low reset.
REQ-008 SHALL have ports: in_valid, in, 1; in_ready, out, 1; in_data, in, DATA_WIDTH*MAIN_TAP, sample k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have ports: weight_input_to_hidden, in, DATA_WIDTH*TOTAL_TAP*N_HIDDEN; weight_hidden_to_output, in, DATA_WIDTH*N_HIDDEN*MAIN_TAP; bias_hidden, in, DATA_WIDTH*N_HIDDEN; bias_output, in, DATA_WIDTH*MAIN_TAP.
REQ-010 SHALL have ports: relu_en, in, 1; clear, in, 1, synchronous window flush.
REQ-011 SHALL have ports: out_valid, out, 1; out_ready, in, 1; decision_layer_output, out, DATA_WIDTH*MAIN_TAP; output_result, out, 2*MAIN_TAP.

Function
REQ-012 Window: TOTAL_TAP-sample shift register; word accepted when in_valid && in_ready; on accept, shift by MAIN_TAP, in_data enters newest positions, sample 0 newest-oldest order preserved.
REQ-013 Fill counter saturates at TOTAL_TAP samples; computation starts only on an accept that makes (or keeps) window full; earlier accepts only fill.
REQ-014 FSM states IDLE, HID, OUT, DONE; in_ready = 1 only in IDLE.
REQ-015 IDLE -> HID on triggering accept; HID: one MAC per cycle, N_HIDDEN*TOTAL_TAP cycles, neuron accumulator preloaded with bias<<FRAC sign-extended.
REQ-016 Hidden result: acc >>> FRAC, zero if negative and relu_en, saturate to DATA_WIDTH signed range; stored in hidden register file.
REQ-017 HID -> OUT after last hidden MAC; OUT: N_HIDDEN*MAIN_TAP MAC cycles, same bias/shift/saturate, no ReLU.
REQ-018 OUT -> DONE: out_valid = 1, decision_layer_output holds results; output_result[2j+:2] = result j bits [FLAG_LSB +: 2].
REQ-019 Latency: triggering accept at cycle T -> out_valid first high at T+1+N_HIDDEN*(TOTAL_TAP+MAIN_TAP) (defaults T+25).
REQ-020 DONE holds outputs stable while out_ready = 0; DONE -> IDLE on out_ready = 1; outputs keep last value afterwards, out_valid drops.
REQ-021 Weights, biases, relu_en sampled each MAC cycle; must be held stable from accept to out_valid.
REQ-022 clear = 1: fill counter to 0, window zeroed, FSM to IDLE, out_valid 0, clear takes priority over accept; result registers unchanged.
REQ-023 All arithmetic signed two's complement; no wrap inside ACC_WIDTH for defaults.

Reset
REQ-024 reset_n = 0 asynchronously: FSM IDLE, window, fill counter, hidden registers, decision_layer_output, output_result, out_valid all 0; in_ready = 1 after release.
REQ-025 Reset mid-HID/OUT/DONE aborts computation; no partial result appears.

Verification
REQ-026 Warm-up: defaults, first word accepted -> no computation, in_ready stays 1; second word -> in_ready 0, out_valid at accept+25.
REQ-027 Bias only: all weights 0, bias_output 0x60 each -> outputs 0x60, output_result 4'b1111.
REQ-028 Saturation: window all 127, all weights 127, biases 0 -> hidden 127, outputs 127, flags 2'b11.
REQ-029 ReLU: input weights -64, samples 64, bias_output 0x20, relu_en 1 -> outputs 0x20, flags 2'b01; relu_en 0 with output weights 64 -> outputs saturate -128.
REQ-030 Back-pressure: out_ready 0 for 10 cycles -> out_valid and outputs constant, in_ready 0; out_ready 1 -> IDLE next cycle.
REQ-031 reset_n low mid-HID and clear mid-OUT -> all outputs per REQ-024/022; next two words re-warm per REQ-026.
